// File: rtl/mips_defs.sv
// Shared definitions for the MIPS core: fetch FSM states and primary opcodes.
package mips_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] inst_idx,   // inst[25:0]; the branch immediate is its low 16 bits
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;

    // Priority: jump over taken branch over fall-through; all sums wrap modulo 2^32.
    always_comb begin
        br_off  = {{14{inst_idx[15]}}, inst_idx[15:0], 2'b00};
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], inst_idx, 2'b00};
        end else if (Branch && zero) begin
            next_pc = pc_plus4 + br_off;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port,
// holds the instruction for one EXEC cycle and retires it.
module inst_fetch
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             zero,
    output logic [31:0]      inst,
    output logic [5:0]       OP,
    output logic             inst_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] instret
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [31:0]      next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .inst_idx (inst_q[25:0]),
        .Branch   (Branch),
        .Jump     (Jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // State and architectural registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC_ALIGNED;
            inst_q    <= 32'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
        end
    end

    // Next-state: ack only matters in S_REQ, stall and branch inputs only in S_EXEC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d      = next_pc;
                    instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs.
    always_comb begin
        imem_req   = (state_q == S_REQ);
        inst_valid = (state_q == S_EXEC);
        imem_addr  = pc_q;
        pc         = pc_q;
        inst       = inst_q;
        OP         = inst_q[31:26];
        instret    = instret_q;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table plus randomized
// instructions checked against a behavioural PC/retire-count model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        zero = 1'b0;

    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4, instret;
    logic [5:0]  OP;

    // Second instance with an unaligned high reset PC, driven in lockstep.
    logic        hi_req, hi_valid;
    logic [31:0] hi_addr, hi_inst, hi_pc, hi_pc4, hi_instret;
    logic [5:0]  hi_op;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_pc, m_hi, m_instret;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(Branch), .Jump(Jump), .zero(zero), .inst(inst), .OP(OP),
        .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4), .instret(instret)
    );

    inst_fetch #(.RESET_PC(32'h8000_0043), .CNT_W(32)) u_dut_hi (
        .clk(clk), .rst(rst), .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(Branch), .Jump(Jump), .zero(zero), .inst(hi_inst), .OP(hi_op),
        .inst_valid(hi_valid), .pc(hi_pc), .pc_plus4(hi_pc4), .instret(hi_instret)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference next PC from the architectural rules, using signed integer offsets.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic b, input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
        if (b && z) begin
            off = int'($signed(w[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    // Called at a negedge; asserts reset mid-cycle and walks through the idle cycle.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc_plus4, 32'd4);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_op", 32'(OP), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_hi_pc", hi_pc, 32'h8000_0040);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        chk("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("idle_inst_kept", inst, 32'd0);
        m_pc = 32'd0;
        m_hi = 32'h8000_0040;
        m_instret = 32'd0;
    endtask

    // Called at a negedge with the DUT in S_REQ; returns at a negedge in S_REQ.
    task automatic do_instr(input logic [31:0] word, input int lat, input logic b,
                            input logic j, input logic z, input int nstall);
        for (int i = 0; i < lat; i++) begin
            chk("req", 32'(imem_req), 32'd1);
            chk("addr", imem_addr, m_pc);
            chk("pc4", pc_plus4, m_pc + 32'd4);
            chk("valid_in_req", 32'(inst_valid), 32'd0);
            imem_ack   = (i == lat - 1);
            imem_rdata = (i == lat - 1) ? word : $urandom;
            Branch = 1'($urandom); Jump = 1'($urandom); zero = 1'($urandom);
            stall  = 1'($urandom);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        Branch = b; Jump = j; zero = z;
        stall = (nstall > 0);
        chk("exec_valid", 32'(inst_valid), 32'd1);
        chk("exec_req", 32'(imem_req), 32'd0);
        chk("exec_inst", inst, word);
        chk("exec_op", 32'(OP), 32'(word[31:26]));
        chk("exec_pc", pc, m_pc);
        chk("exec_hi_pc", hi_pc, m_hi);
        chk("exec_instret", instret, m_instret);
        for (int s = 0; s < nstall; s++) begin
            imem_ack = 1'b1;
            imem_rdata = ~word;
            @(negedge clk);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, word);
            chk("stall_pc", pc, m_pc);
            chk("stall_instret", instret, m_instret);
        end
        stall = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        m_pc = ref_next(m_pc, word, b, j, z);
        m_hi = ref_next(m_hi, word, b, j, z);
        m_instret = m_instret + 32'd1;
        chk("next_pc", pc, m_pc);
        chk("next_hi_pc", hi_pc, m_hi);
        chk("instret", instret, m_instret);
        chk("pc_align", 32'(pc[1:0]), 32'd0);
    endtask

    typedef struct {
        logic        rst_before;
        logic [31:0] word;
        int          lat;
        logic        b, j, z;
        int          nstall;
        logic [31:0] exp_pc;
        logic        chk_hi;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t vecs[16];

    localparam logic [31:0] W_R   = 32'h0022_1820;  // add
    localparam logic [31:0] W_BM4 = 32'h1022_FFFC;  // beq imm -4
    localparam logic [31:0] W_BM2 = 32'h1022_FFFE;  // beq imm -2
    localparam logic [31:0] W_J1  = 32'h0800_0100;  // j 0x100
    localparam logic [31:0] W_J2  = 32'h0800_0200;  // j 0x200 (imm field also +0x200)

    initial begin
        vecs[0]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0004, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0008, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_000C, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0010, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, W_BM4, 1, 1'b1, 1'b0, 1'b1, 0, 32'h0000_0004, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0008, 1'b0, 32'd0};
        vecs[6]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_000C, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0010, 1'b0, 32'd0};
        vecs[8]  = '{1'b0, W_BM4, 1, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0014, 1'b0, 32'd0};
        vecs[9]  = '{1'b0, W_R,   6, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0018, 1'b0, 32'd0};
        vecs[10] = '{1'b0, W_R,   2, 1'b0, 1'b0, 1'b0, 3, 32'h0000_001C, 1'b0, 32'd0};
        vecs[11] = '{1'b0, W_J1,  1, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0400, 1'b0, 32'd0};
        vecs[12] = '{1'b0, W_J2,  1, 1'b1, 1'b1, 1'b1, 0, 32'h0000_0800, 1'b0, 32'd0};
        vecs[13] = '{1'b1, W_J1,  1, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0400, 1'b1, 32'h8000_0400};
        vecs[14] = '{1'b1, W_BM2, 1, 1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFC, 1'b0, 32'd0};
        vecs[15] = '{1'b0, W_R,   1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b0, 32'd0};

        @(negedge clk);
        pulse_reset();

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst_before) pulse_reset();
            do_instr(vecs[i].word, vecs[i].lat, vecs[i].b, vecs[i].j, vecs[i].z,
                     vecs[i].nstall);
            chk("vec_pc", pc, vecs[i].exp_pc);
            if (vecs[i].chk_hi) chk("vec_hi_pc", hi_pc, vecs[i].exp_hi);
            if (i == 2) chk("instret_after_3", instret, 32'd3);
        end

        for (int k = 0; k < 40; k++) begin
            do_instr($urandom, int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom),
                     1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
